// File: rtl/packet_tx_framer.sv
// Serializes reward-stage packet descriptors into 16-bit TX words and reports per-packet energy cost.
// Optional trailing XOR checksum word is enabled by defining PKT_TX_CHECKSUM_EN.
module packet_tx_framer (
  input  logic        clk,
  input  logic        nrst,
  input  logic        reward_done,
  input  logic [2:0]  rPacketType,
  input  logic [15:0] rSourceID,
  input  logic [15:0] rSourceHops,
  input  logic [15:0] rQValue,
  input  logic [15:0] rEnergyLeft,
  input  logic [15:0] rDestinationID,
  input  logic [15:0] rHopsFromCH,
  input  logic [5:0]  rTimeslot,
  input  logic        tx_setting,
  input  logic        tx_ready,
  output logic [15:0] tx_word,
  output logic        tx_valid,
  output logic        tx_last,
  output logic        busy,
  output logic        nrg_valid,
  output logic [15:0] nrg_cost,
  output logic [7:0]  drop_cnt,
  output logic [1:0]  dbgState
);

  // Handshake: a word transfers on a rising edge where tx_valid && tx_ready; until then
  // tx_word/tx_valid/tx_last are registered and held unchanged.

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, COST = 2'd2} state_t;

  typedef struct packed {
    logic [2:0]  ptype;
    logic        txSet;
    logic [5:0]  slot;
    logic [15:0] src;
    logic [15:0] hops;
    logic [15:0] qval;
    logic [15:0] energy;
    logic [15:0] dest;
    logic [15:0] hfc;
    logic [15:0] cost;
  } desc_t;

  function automatic logic [15:0] calcCost(input logic txSet, input logic [15:0] hops);
    if (!txSet || hops <= 16'd1) return 16'h0005;
    else if (hops == 16'd2)      return 16'h0009;
    else if (hops == 16'd3)      return 16'h0011;
    else                         return 16'h001B;
  endfunction

  function automatic logic [2:0] fieldCount(input logic [2:0] ptype);
    case (ptype)
      3'b000:  return 3'd5;
      3'b001:  return 3'd4;
      3'b010:  return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  // Data packets use a short layout; the other types share a common 5-word prefix.
  function automatic logic [15:0] wordAt(input desc_t d, input logic [2:0] idx);
    logic [15:0] w;
    w = 16'h0000;
    if (d.ptype == 3'b001) begin
      case (idx)
        3'd0: w = {d.ptype, d.txSet, 6'b0, d.slot};
        3'd1: w = d.src;
        3'd2: w = d.dest;
        3'd3: w = d.energy;
        default: w = 16'h0000;
      endcase
    end else begin
      case (idx)
        3'd0: w = {d.ptype, d.txSet, 6'b0, d.slot};
        3'd1: w = d.src;
        3'd2: w = d.hops;
        3'd3: w = d.qval;
        3'd4: w = d.energy;
        3'd5: w = (d.ptype == 3'b011) ? d.dest : d.hfc;
        3'd6: w = d.hfc;
        default: w = 16'h0000;
      endcase
    end
    return w;
  endfunction

  state_t      state, stateNext;
  desc_t       aReg, pReg, newDesc;
  logic        aValid, pValid;
  logic [2:0]  idx, nextIdx, lastIdx;
  logic [15:0] csum, nextWord;
  logic        loadSend, advance, finish, costDone, promote, dropEvt, typeOk;

  assign typeOk = (rPacketType[2] == 1'b0);
  assign newDesc = '{ptype: rPacketType, txSet: tx_setting, slot: rTimeslot,
                     src: rSourceID, hops: rSourceHops, qval: rQValue,
                     energy: rEnergyLeft, dest: rDestinationID, hfc: rHopsFromCH,
                     cost: calcCost(tx_setting, rSourceHops)};

`ifdef PKT_TX_CHECKSUM_EN
  assign lastIdx = fieldCount(aReg.ptype);
`else
  assign lastIdx = fieldCount(aReg.ptype) - 3'd1;
`endif

  // The slot after the final field can only be reached with the checksum enabled.
  assign nextIdx  = idx + 3'd1;
  assign nextWord = (nextIdx == fieldCount(aReg.ptype)) ? (csum ^ tx_word) : wordAt(aReg, nextIdx);
  assign busy     = (state != IDLE);
  assign dbgState = state;

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    loadSend  = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    costDone  = 1'b0;
    promote   = 1'b0;
    case (state)
      IDLE: begin
        if (aValid) begin
          stateNext = SEND;
          loadSend  = 1'b1;
        end else if (pValid) begin
          promote = 1'b1;
        end
      end
      SEND: begin
        if (tx_valid && tx_ready) begin
          if (tx_last) begin
            stateNext = COST;
            finish    = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end
      end
      COST: begin
        costDone  = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // A capture in the COST cycle sees the pre-edge P, so a fresh entry never skips the queue.
  always_comb begin
    dropEvt = 1'b0;
    if (reward_done) begin
      if (!typeOk) dropEvt = 1'b1;
      else if ((aValid || promote) && pValid && !promote) dropEvt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      aReg     <= '0;
      pReg     <= '0;
      aValid   <= 1'b0;
      pValid   <= 1'b0;
      drop_cnt <= 8'h00;
    end else begin
      if (costDone) begin
        if (pValid) begin
          aReg   <= pReg;
          pValid <= 1'b0;
        end else begin
          aValid <= 1'b0;
        end
      end
      if (promote) begin
        aReg   <= pReg;
        aValid <= 1'b1;
        pValid <= 1'b0;
      end
      if (reward_done && typeOk) begin
        if (!aValid && !promote) begin
          aReg   <= newDesc;
          aValid <= 1'b1;
        end else if (!pValid || promote) begin
          pReg   <= newDesc;
          pValid <= 1'b1;
        end
      end
      if (dropEvt && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      tx_word   <= 16'h0000;
      tx_valid  <= 1'b0;
      tx_last   <= 1'b0;
      nrg_valid <= 1'b0;
      nrg_cost  <= 16'h0000;
      idx       <= 3'd0;
      csum      <= 16'h0000;
    end else begin
      nrg_valid <= 1'b0;
      if (loadSend) begin
        tx_valid <= 1'b1;
        tx_word  <= wordAt(aReg, 3'd0);
        tx_last  <= 1'b0;
        idx      <= 3'd0;
        csum     <= 16'h0000;
      end
      if (advance) begin
        idx     <= nextIdx;
        csum    <= csum ^ tx_word;
        tx_word <= nextWord;
        tx_last <= (nextIdx == lastIdx);
      end
      if (finish) begin
        tx_valid  <= 1'b0;
        tx_last   <= 1'b0;
        tx_word   <= 16'h0000;
        nrg_valid <= 1'b1;
        nrg_cost  <= aReg.cost;
      end
    end
  end

endmodule

// File: tb/tb_packet_tx_framer.sv
// Directed self-checking bench for packet_tx_framer (also valid with PKT_TX_CHECKSUM_EN defined).
module tb_packet_tx_framer;

  logic        clk, nrst, reward_done, tx_setting, tx_ready;
  logic [2:0]  rPacketType;
  logic [15:0] rSourceID, rSourceHops, rQValue, rEnergyLeft, rDestinationID, rHopsFromCH;
  logic [5:0]  rTimeslot;
  logic [15:0] tx_word, nrg_cost;
  logic        tx_valid, tx_last, busy, nrg_valid;
  logic [7:0]  drop_cnt;
  logic [1:0]  dbgState;

  int nCompared = 0;
  int nMismatch = 0;
  logic [7:0] expDrop;

  packet_tx_framer dut (
    .clk(clk), .nrst(nrst), .reward_done(reward_done), .rPacketType(rPacketType),
    .rSourceID(rSourceID), .rSourceHops(rSourceHops), .rQValue(rQValue),
    .rEnergyLeft(rEnergyLeft), .rDestinationID(rDestinationID), .rHopsFromCH(rHopsFromCH),
    .rTimeslot(rTimeslot), .tx_setting(tx_setting), .tx_ready(tx_ready),
    .tx_word(tx_word), .tx_valid(tx_valid), .tx_last(tx_last), .busy(busy),
    .nrg_valid(nrg_valid), .nrg_cost(nrg_cost), .drop_cnt(drop_cnt), .dbgState(dbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // driver: one-cycle reward_done pulse; called and returns #1 after a rising edge
  task automatic pulse(input logic [2:0] t, input logic ts, input logic [5:0] slot,
                       input logic [15:0] src, input logic [15:0] hops, input logic [15:0] q,
                       input logic [15:0] en, input logic [15:0] dest, input logic [15:0] hfc);
    rPacketType = t; tx_setting = ts; rTimeslot = slot; rSourceID = src; rSourceHops = hops;
    rQValue = q; rEnergyLeft = en; rDestinationID = dest; rHopsFromCH = hfc;
    reward_done = 1'b1;
    @(posedge clk); #1;
    reward_done = 1'b0;
  endtask

  // receiver: accepts one packet, returns #1 into the cycle after the last handshake
  task automatic recv_packet(input string name, input logic [15:0] fw[8], input int nf,
                             input logic [15:0] expCost, input int stallIdx, input int stallLen);
    logic [15:0] ew[8];
    int n;
    int waitC;
    for (int i = 0; i < 8; i++) ew[i] = fw[i];
    n = nf;
`ifdef PKT_TX_CHECKSUM_EN
    ew[nf] = 16'h0000;
    for (int i = 0; i < nf; i++) ew[nf] = ew[nf] ^ fw[i];
    n = nf + 1;
`endif
    waitC = 0;
    while (tx_valid !== 1'b1 && waitC < 20) begin @(posedge clk); #1; waitC++; end
    nCompared++;
    if (tx_valid !== 1'b1) begin
      nMismatch++; $display("FAIL %s start: got tx_valid %b want 1", name, tx_valid);
      return;
    end
    tx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      nCompared++;
      if (tx_word !== ew[i] || tx_valid !== 1'b1) begin
        nMismatch++; $display("FAIL %s word%0d: got %h/%b want %h/1", name, i, tx_word, tx_valid, ew[i]);
      end
      nCompared++;
      if (tx_last !== (i == n - 1)) begin
        nMismatch++; $display("FAIL %s last%0d: got %b want %b", name, i, tx_last, (i == n - 1));
      end
      if (i == stallIdx) begin
        tx_ready = 1'b0;
        repeat (stallLen) begin
          @(posedge clk); #1;
          nCompared++;
          if (tx_word !== ew[i] || tx_valid !== 1'b1 || tx_last !== (i == n - 1)) begin
            nMismatch++; $display("FAIL %s stall%0d: got %h/%b want %h/1", name, i, tx_word, tx_valid, ew[i]);
          end
        end
        tx_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    nCompared++;
    if (nrg_valid !== 1'b1 || nrg_cost !== expCost) begin
      nMismatch++; $display("FAIL %s cost: got %b/%h want 1/%h", name, nrg_valid, nrg_cost, expCost);
    end
    nCompared++;
    if (tx_valid !== 1'b0) begin
      nMismatch++; $display("FAIL %s post_valid: got %b want 0", name, tx_valid);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b1; reward_done = 1'b0; tx_ready = 1'b0; tx_setting = 1'b0; rPacketType = 3'd0;
    rSourceID = 0; rSourceHops = 0; rQValue = 0; rEnergyLeft = 0; rDestinationID = 0;
    rHopsFromCH = 0; rTimeslot = 0;
    repeat (2) @(posedge clk);
    #1;
    nCompared++;
    if ({tx_word, tx_valid, tx_last, busy, nrg_valid, nrg_cost, drop_cnt} !== 51'd0) begin
      nMismatch++; $display("FAIL reset_outputs: got %h %b %b %b %b %h %h want all zero",
                            tx_word, tx_valid, tx_last, busy, nrg_valid, nrg_cost, drop_cnt);
    end
    nrst = 1'b0;
    expDrop = 8'd0;
    @(posedge clk); #1;
  endtask

  task automatic test_heartbeat();
    logic [15:0] w[8];
    w = '{16'h1005, 16'h000C, 16'h0003, 16'h3555, 16'h7FFC, 16'h0, 16'h0, 16'h0};
    pulse(3'b000, 1'b1, 6'd5, 16'h000C, 16'h0003, 16'h3555, 16'h7FFC, 16'h0, 16'h0);
    nCompared++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      nMismatch++; $display("FAIL hb_latency_e0: got %b/%b want 0/0", tx_valid, busy);
    end
    @(posedge clk); #1;
    nCompared++;
    if (tx_valid !== 1'b1 || busy !== 1'b1 || tx_word !== 16'h1005) begin
      nMismatch++; $display("FAIL hb_latency_e1: got %b/%b/%h want 1/1/1005", tx_valid, busy, tx_word);
    end
    recv_packet("heartbeat", w, 5, 16'h0011, -1, 0);
    nCompared++;
    if (busy !== 1'b1) begin
      nMismatch++; $display("FAIL hb_busy_cost: got %b want 1", busy);
    end
    @(posedge clk); #1;
    nCompared++;
    if (nrg_valid !== 1'b0 || busy !== 1'b0) begin
      nMismatch++; $display("FAIL hb_after_cost: got %b/%b want 0/0", nrg_valid, busy);
    end
  endtask

  task automatic test_membership_stall();
    logic [15:0] w[8];
    w = '{16'h6002, 16'h000C, 16'h0003, 16'h3555, 16'h7FF2, 16'h0017, 16'h0001, 16'h0};
    pulse(3'b011, 1'b0, 6'd2, 16'h000C, 16'h0003, 16'h3555, 16'h7FF2, 16'h0017, 16'h0001);
    recv_packet("membership", w, 7, 16'h0005, 2, 3);
    @(posedge clk); #1;
  endtask

  task automatic test_cost_capture();
    logic [15:0] w[8];
    logic [15:0] d[8];
    w = '{16'h0003, 16'h0001, 16'h0001, 16'h0002, 16'h0003, 16'h0, 16'h0, 16'h0};
    d = '{16'h3009, 16'h00AA, 16'h00BB, 16'h0CCC, 16'h0, 16'h0, 16'h0, 16'h0};
    pulse(3'b000, 1'b0, 6'd3, 16'h0001, 16'h0001, 16'h0002, 16'h0003, 16'h0, 16'h0);
    recv_packet("hb_short", w, 5, 16'h0005, -1, 0);
    pulse(3'b001, 1'b1, 6'd9, 16'h00AA, 16'h0002, 16'h0, 16'h0CCC, 16'h00BB, 16'h0);
    nCompared++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      nMismatch++; $display("FAIL cc_idle1: got %b/%b want 0/0", tx_valid, busy);
    end
    @(posedge clk); #1;
    nCompared++;
    if (tx_valid !== 1'b0) begin
      nMismatch++; $display("FAIL cc_idle2: got %b want 0", tx_valid);
    end
    @(posedge clk); #1;
    nCompared++;
    if (tx_valid !== 1'b1 || tx_word !== 16'h3009) begin
      nMismatch++; $display("FAIL cc_header: got %b/%h want 1/3009", tx_valid, tx_word);
    end
    recv_packet("data_from_p", d, 4, 16'h0009, -1, 0);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] w1[8];
    logic [15:0] w2[8];
    int seen;
    w1 = '{16'h3001, 16'h0101, 16'h0202, 16'h0303, 16'h0, 16'h0, 16'h0, 16'h0};
    w2 = '{16'h1002, 16'h0404, 16'h0004, 16'h0505, 16'h0606, 16'h0, 16'h0, 16'h0};
    pulse(3'b001, 1'b1, 6'd1, 16'h0101, 16'h0000, 16'h0, 16'h0303, 16'h0202, 16'h0);
    pulse(3'b000, 1'b1, 6'd2, 16'h0404, 16'h0004, 16'h0505, 16'h0606, 16'h0, 16'h0);
    pulse(3'b001, 1'b0, 6'd3, 16'hDEAD, 16'h0001, 16'h0, 16'hBEEF, 16'hCAFE, 16'h0);
    expDrop = expDrop + 8'd1;
    nCompared++;
    if (drop_cnt !== expDrop) begin
      nMismatch++; $display("FAIL b2b_drop3: got %h want %h", drop_cnt, expDrop);
    end
    recv_packet("b2b_first", w1, 4, 16'h0005, -1, 0);
    pulse(3'b010, 1'b0, 6'd4, 16'h1234, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0);
    expDrop = expDrop + 8'd1;
    nCompared++;
    if (drop_cnt !== expDrop || tx_valid !== 1'b0) begin
      nMismatch++; $display("FAIL b2b_drop_cost: got %h/%b want %h/0", drop_cnt, tx_valid, expDrop);
    end
    @(posedge clk); #1;
    nCompared++;
    if (tx_valid !== 1'b1 || tx_word !== 16'h1002) begin
      nMismatch++; $display("FAIL b2b_gap: got %b/%h want 1/1002", tx_valid, tx_word);
    end
    recv_packet("b2b_second", w2, 5, 16'h001B, -1, 0);
    seen = 0;
    repeat (10) begin @(posedge clk); #1; if (tx_valid !== 1'b0) seen++; end
    nCompared++;
    if (seen !== 0) begin
      nMismatch++; $display("FAIL b2b_no_third: got %0d valid cycles want 0", seen);
    end
  endtask

  task automatic test_invalid();
    int seen;
    pulse(3'b101, 1'b0, 6'd0, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    expDrop = expDrop + 8'd1;
    nCompared++;
    if (drop_cnt !== expDrop) begin
      nMismatch++; $display("FAIL inv_drop: got %h want %h", drop_cnt, expDrop);
    end
    seen = 0;
    repeat (5) begin @(posedge clk); #1; if (tx_valid !== 1'b0) seen++; end
    nCompared++;
    if (seen !== 0) begin
      nMismatch++; $display("FAIL inv_no_valid: got %0d valid cycles want 0", seen);
    end
    rPacketType = 3'b101;
    reward_done = 1'b1;
    repeat (256) @(posedge clk);
    #1;
    reward_done = 1'b0;
    nCompared++;
    if (drop_cnt !== 8'hFF) begin
      nMismatch++; $display("FAIL inv_saturate: got %h want ff", drop_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_packet();
    logic [15:0] w[8];
    int seen;
    int waitC;
    w = '{16'h0003, 16'h0001, 16'h0001, 16'h0002, 16'h0003, 16'h0, 16'h0, 16'h0};
    pulse(3'b010, 1'b1, 6'd7, 16'h0021, 16'h0002, 16'h1111, 16'h2222, 16'h0033, 16'h0004);
    pulse(3'b010, 1'b0, 6'd8, 16'h0022, 16'h0002, 16'h1112, 16'h2223, 16'h0034, 16'h0005);
    waitC = 0;
    while (tx_valid !== 1'b1 && waitC < 20) begin @(posedge clk); #1; waitC++; end
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tx_ready = 1'b0;
    nCompared++;
    if (tx_word !== 16'h1111 || tx_valid !== 1'b1) begin
      nMismatch++; $display("FAIL rst_word3: got %h/%b want 1111/1", tx_word, tx_valid);
    end
    #2 nrst = 1'b1;
    #1;
    nCompared++;
    if ({tx_word, tx_valid, tx_last, busy, nrg_valid, nrg_cost, drop_cnt} !== 51'd0) begin
      nMismatch++; $display("FAIL rst_async: got %h %b %b %b %b %h %h want all zero",
                            tx_word, tx_valid, tx_last, busy, nrg_valid, nrg_cost, drop_cnt);
    end
    @(posedge clk); #1;
    nrst = 1'b0;
    expDrop = 8'd0;
    seen = 0;
    repeat (10) begin @(posedge clk); #1; if (tx_valid !== 1'b0 || nrg_valid !== 1'b0) seen++; end
    nCompared++;
    if (seen !== 0) begin
      nMismatch++; $display("FAIL rst_quiet: got %0d active cycles want 0", seen);
    end
    pulse(3'b000, 1'b0, 6'd3, 16'h0001, 16'h0001, 16'h0002, 16'h0003, 16'h0, 16'h0);
    recv_packet("after_reset", w, 5, 16'h0005, -1, 0);
  endtask

  initial begin
    test_reset();
    test_heartbeat();
    test_membership_stall();
    test_cost_capture();
    test_back_to_back();
    test_invalid();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
